// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice resolved per stage, carry registered between stages.
// Optional OVERFLOW_FLAG_EN adds a two's-complement overflow output (ovf) that travels with sum.
module pipelined_rca #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   sum
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                  ovf
`endif
);

    localparam int CHUNK = DATA_WIDTH / NUM_STAGES;

    if ((NUM_STAGES < 1) || (NUM_STAGES > DATA_WIDTH) || (DATA_WIDTH % NUM_STAGES != 0)) begin : g_bad_cfg
        $error("pipelined_rca: DATA_WIDTH must be a multiple of NUM_STAGES");
    end

    // Handshake: a stage loads when it is empty or its successor is loading this cycle;
    // a valid stage that cannot advance keeps every register unchanged.
    logic [NUM_STAGES-1:0] stage_valid;
    logic [NUM_STAGES-1:0] stage_ready;

    always_comb begin
        logic rdy;
        stage_ready = '0;
        rdy         = out_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            rdy            = !stage_valid[k] || rdy;
            stage_ready[k] = rdy;
        end
    end

    function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] x,
                                              input logic [CHUNK-1:0] y,
                                              input logic             c);
        logic [CHUNK-1:0] s;
        logic             cy;
        s  = '0;
        cy = c;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
        end
        return {cy, s};
    endfunction

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Operand bits still to be added shrink by one chunk per stage; the partial sum grows.
        localparam int W  = DATA_WIDTH - k * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [W-1:0]  src_a;
        logic [W-1:0]  src_b;
        logic          src_c;
        logic          src_v;
        logic [CHUNK:0] res;
        logic [SW-1:0] next_sum;

        logic          valid_q;
        logic          carry_q;
        logic [SW-1:0] sum_q;

        if (k == 0) begin : g_first
            assign src_a    = a;
            assign src_b    = b;
            assign src_c    = cin;
            assign src_v    = in_valid;
            assign next_sum = res[CHUNK-1:0];
        end else begin : g_next
            assign src_a    = g_stage[k-1].g_fwd.a_q;
            assign src_b    = g_stage[k-1].g_fwd.b_q;
            assign src_c    = g_stage[k-1].carry_q;
            assign src_v    = g_stage[k-1].valid_q;
            assign next_sum = {res[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        assign res = ripple(src_a[CHUNK-1:0], src_b[CHUNK-1:0], src_c);

        always_ff @(posedge clk) begin
            if (!resetn) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (stage_ready[k]) begin
                valid_q <= src_v;
                if (src_v) begin
                    carry_q <= res[CHUNK];
                    sum_q   <= next_sum;
                end
            end
        end

        if (k < NUM_STAGES - 1) begin : g_fwd
            logic [W-CHUNK-1:0] a_q;
            logic [W-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (stage_ready[k] && src_v) begin
                    a_q <= src_a[W-1:CHUNK];
                    b_q <= src_b[W-1:CHUNK];
                end
            end
        end

        assign stage_valid[k] = valid_q;
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[NUM_STAGES-1];
    assign sum       = {g_stage[NUM_STAGES-1].carry_q, g_stage[NUM_STAGES-1].sum_q};

`ifdef OVERFLOW_FLAG_EN
    // Carry into the MSB is recovered as a^b^s at that bit position.
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else if (stage_ready[NUM_STAGES-1] && g_stage[NUM_STAGES-1].src_v) begin
            ovf_q <= g_stage[NUM_STAGES-1].src_a[CHUNK-1] ^ g_stage[NUM_STAGES-1].src_b[CHUNK-1]
                   ^ g_stage[NUM_STAGES-1].res[CHUNK-1] ^ g_stage[NUM_STAGES-1].res[CHUNK];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: random and directed operands checked against an arithmetic reference model.
module tb_pipelined_rca;

    localparam int DW = 16;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [DW:0]   sum;
    logic          ovf_s;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] got_q[$];
    int            exp_cyc_q[$];
    int            got_cyc_q[$];

`ifdef OVERFLOW_FLAG_EN
    logic ovf;
    assign ovf_s = ovf;
`else
    assign ovf_s = 1'b0;
`endif

    pipelined_rca #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: {ovf, a+b+cin} from plain integer arithmetic.
    function automatic logic [DW+1:0] model(input logic [DW-1:0] xa, input logic [DW-1:0] xb, input logic xc);
        longint us;
        longint ss;
        longint lim;
        logic   o;
        us  = longint'(xa) + longint'(xb) + longint'(xc);
        ss  = longint'($signed(xa)) + longint'($signed(xb)) + longint'(xc);
        lim = longint'(1) << (DW - 1);
        o   = (ss >= lim) || (ss < -lim);
`ifndef OVERFLOW_FLAG_EN
        o = 1'b0;
`endif
        return {o, us[DW:0]};
    endfunction

    // One clock: record handshakes at the falling edge, return #1 after the rising edge.
    task automatic tick(output bit took);
        @(negedge clk);
        took = resetn && in_valid && in_ready;
        if (took) begin
            exp_q.push_back(model(a, b, cin));
            exp_cyc_q.push_back(cyc);
        end
        if (resetn && out_valid && out_ready) begin
            got_q.push_back({ovf_s, sum});
            got_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [DW-1:0] xa, input logic [DW-1:0] xb, input logic xc,
                        input int budget, output bit ok);
        bit t;
        a        = xa;
        b        = xb;
        cin      = xc;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(t);
            if (t) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        bit t;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick(t);
        end
        if (got_q.size() >= exp_q.size()) ok = 1'b1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        exp_cyc_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic test_reset();
        bit t;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick(t);
        tick(t);
        resetn = 1'b1;
        clear_queues();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (sum !== 17'h00000) begin
            miscompares++;
            $display("FAIL reset_sum: got %h expected 00000", sum);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [DW:0] want [2];
        logic [DW-1:0] oa [2];
        logic [DW-1:0] ob [2];
        logic          oc [2];
        want[0] = 17'h10000; oa[0] = 16'hFFFF; ob[0] = 16'h0001; oc[0] = 1'b0;
        want[1] = 17'h05556; oa[1] = 16'h1234; ob[1] = 16'h4321; oc[1] = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            clear_queues();
            send(oa[n], ob[n], oc[n], 10, ok);
            drain(20, ok);
            vectors++;
            if (!ok || got_q.size() != 1) begin
                miscompares++;
                $display("FAIL single_count: got %0d results expected 1", got_q.size());
            end else begin
                vectors++;
                if (got_q[0][DW:0] !== want[n]) begin
                    miscompares++;
                    $display("FAIL single_sum: got %h expected %h", got_q[0][DW:0], want[n]);
                end
                vectors++;
                if (got_cyc_q[0] - exp_cyc_q[0] != NS) begin
                    miscompares++;
                    $display("FAIL single_latency: got %0d expected %0d", got_cyc_q[0] - exp_cyc_q[0], NS);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_in_ready: got %b expected 1 at op %0d", in_ready, n);
            end
            send(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1, ok);
        end
        drain(30, ok);
        vectors++;
        if (!ok || got_q.size() != 8 || exp_q.size() != 8) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results expected 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL b2b_sum: got %h expected %h at op %0d", got_q[i], exp_q[i], i);
                end
                vectors++;
                if (got_cyc_q[i] != got_cyc_q[0] + i) begin
                    miscompares++;
                    $display("FAIL b2b_consecutive: got cycle %0d expected %0d", got_cyc_q[i], got_cyc_q[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit t;
        int accepted = 0;
        logic [DW:0] held;
        clear_queues();
        out_ready = 1'b0;
        a         = DW'($urandom);
        b         = DW'($urandom);
        cin       = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(t);
            if (t) begin
                accepted++;
                a   = DW'($urandom);
                b   = DW'($urandom);
                cin = 1'($urandom_range(0, 1));
            end
        end
        vectors++;
        if (accepted != NS) begin
            miscompares++;
            $display("FAIL bp_accepted: got %0d expected %0d", accepted, NS);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_in_ready: got %b expected 0", in_ready);
        end
        held = sum;
        tick(t);
        tick(t);
        vectors++;
        if (exp_q.size() == 0 || sum !== held || sum !== exp_q[0][DW:0] || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: got %h valid %b expected stable %h", sum, out_valid,
                     (exp_q.size() != 0) ? exp_q[0][DW:0] : held);
        end
        // The pending fifth operand is still presented and must enter once space frees.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(t);
            if (t) break;
        end
        in_valid = 1'b0;
        drain(30, ok);
        vectors++;
        if (!ok || got_q.size() != NS + 1 || exp_q.size() != NS + 1) begin
            miscompares++;
            $display("FAIL bp_count: got %0d results expected %0d", got_q.size(), NS + 1);
        end else begin
            for (int i = 0; i < NS + 1; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL bp_order: got %h expected %h at op %0d", got_q[i], exp_q[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_flush();
        bit ok;
        bit t;
        clear_queues();
        out_ready = 1'b1;
        send(DW'($urandom), DW'($urandom), 1'b1, 1, ok);
        send(DW'($urandom), DW'($urandom), 1'b0, 1, ok);
        tick(t);
        resetn = 1'b0;
        tick(t);
        resetn = 1'b1;
        clear_queues();
        vectors++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            miscompares++;
            $display("FAIL flush_state: got valid %b sum %h expected 0 00000", out_valid, sum);
        end
        for (int i = 0; i < 6; i++) tick(t);
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL flush_leak: got %0d outputs expected 0", got_q.size());
        end
        send(16'hABCD, 16'h1111, 1'b1, 5, ok);
        drain(20, ok);
        vectors++;
        if (!ok || got_q.size() != 1) begin
            miscompares++;
            $display("FAIL flush_after: got %0d results expected 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0][DW:0] !== 17'h0BCDF || got_cyc_q[0] - exp_cyc_q[0] != NS) begin
                miscompares++;
                $display("FAIL flush_after_sum: got %h latency %0d expected 0BCDF latency %0d",
                         got_q[0][DW:0], got_cyc_q[0] - exp_cyc_q[0], NS);
            end
        end
    endtask

`ifdef OVERFLOW_FLAG_EN
    task automatic test_ovf();
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        send(16'h7FFF, 16'h0001, 1'b0, 5, ok);
        send(16'hFFFF, 16'h0001, 1'b0, 5, ok);
        drain(20, ok);
        vectors++;
        if (!ok || got_q.size() != 2) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d results expected 2", got_q.size());
        end else begin
            vectors++;
            if (got_q[0] !== 18'h28000) begin
                miscompares++;
                $display("FAIL ovf_pos: got ovf,sum %h expected 28000", got_q[0]);
            end
            vectors++;
            if (got_q[1] !== 18'h10000) begin
                miscompares++;
                $display("FAIL ovf_none: got ovf,sum %h expected 10000", got_q[1]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
`ifdef OVERFLOW_FLAG_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
